// File: rtl/mio_bus_if.sv
// rtl/mio_bus_if.sv - CPU-side memory/IO bus between the core and mio_bus_ctrl
interface mio_bus_if;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [31:0] Data_in;
    logic        MIO_ready;

    modport master (
        output CPU_MIO, mem_w, Addr_out, Data_out,
        input  Data_in, MIO_ready
    );

    modport slave (
        input  CPU_MIO, mem_w, Addr_out, Data_out,
        output Data_in, MIO_ready
    );
endinterface

// File: rtl/mio_bus_ctrl.sv
// rtl/mio_bus_ctrl.sv - memory/IO bus controller: RAM wait states, switch/LED/timer registers
module mio_bus_ctrl #(
    parameter int RAM_WAIT = 1,
    parameter int RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              reset,
    mio_bus_if.slave          bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw,
    output logic [15:0]       led,
    output logic              cnt_irq
);
    localparam logic [31:0] ADDR_SW    = 32'hF000_0000;
    localparam logic [31:0] ADDR_TMR   = 32'hF000_0004;
    localparam logic [31:0] ADDR_STAT  = 32'hF000_0008;
    localparam logic [3:0]  WAIT_LOAD  = 4'(RAM_WAIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t      state, next_state;
    logic [31:0] req_addr, req_data;
    logic        req_we;
    logic [3:0]  wait_cnt;
    logic [31:0] timer, reload;
    logic [31:0] periph_rdata;

    logic take_req, req_is_ram, in_access, wait_last;
    logic periph_rd, led_wr, tmr_wr, irq_clr;

    assign take_req   = (state == S_IDLE) && bus.CPU_MIO;
    assign req_is_ram = (req_addr[31:12] == 20'h0);
    assign in_access  = (state == S_ACCESS);
    assign wait_last  = (state == S_WAIT) && (wait_cnt == 4'd0);
    assign periph_rd  = in_access && !req_is_ram && !req_we;
    assign led_wr     = in_access && req_we && (req_addr == ADDR_SW);
    assign tmr_wr     = in_access && req_we && (req_addr == ADDR_TMR);
    assign irq_clr    = in_access && !req_we && (req_addr == ADDR_STAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (bus.CPU_MIO) next_state = S_ACCESS;
            S_ACCESS: next_state = req_is_ram ? S_WAIT : S_DONE;
            S_WAIT:   if (wait_cnt == 4'd0) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        periph_rdata = 32'h0;
        case (req_addr)
            ADDR_SW:   periph_rdata = {16'h0, sw};
            ADDR_TMR:  periph_rdata = timer;
            ADDR_STAT: periph_rdata = {31'h0, cnt_irq};
            default:   periph_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr      <= 32'h0;
            req_data      <= 32'h0;
            req_we        <= 1'b0;
            wait_cnt      <= 4'd0;
            ram_addr      <= '0;
            ram_we        <= 1'b0;
            ram_wdata     <= 32'h0;
            bus.Data_in   <= 32'h0;
            bus.MIO_ready <= 1'b0;
            led           <= 16'h0;
            timer         <= 32'hFFFF_FFFF;
            reload        <= 32'hFFFF_FFFF;
            cnt_irq       <= 1'b0;
        end else begin
            ram_we        <= 1'b0;
            bus.MIO_ready <= (next_state == S_DONE);

            // RAM outputs are registered on acceptance so they are live for the whole ACCESS cycle
            if (take_req) begin
                req_addr <= bus.Addr_out;
                req_data <= bus.Data_out;
                req_we   <= bus.mem_w;
                if (bus.Addr_out[31:12] == 20'h0) begin
                    ram_addr  <= bus.Addr_out[RAM_AW+1:2];
                    ram_wdata <= bus.Data_out;
                    ram_we    <= bus.mem_w;
                end
            end

            if (in_access)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_WAIT && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;

            if (periph_rd)
                bus.Data_in <= periph_rdata;
            else if (wait_last && !req_we)
                bus.Data_in <= ram_rdata;

            if (led_wr)
                led <= req_data[15:0];

            // A bus write to the timer overrides that cycle's decrement or wrap
            if (tmr_wr) begin
                timer  <= req_data;
                reload <= req_data;
            end else if (timer == 32'h0) begin
                timer <= reload;
            end else begin
                timer <= timer - 32'h1;
            end

            if (timer == 32'h0 && !tmr_wr)
                cnt_irq <= 1'b1;
            else if (irq_clr)
                cnt_irq <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb/tb_mio_bus_ctrl.sv - randomized self-checking bench for mio_bus_ctrl against a transaction model
module tb_mio_bus_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata, ram_rdata;
    logic [15:0] sw, led;
    logic        cnt_irq;

    always #5 clk = ~clk;

    mio_bus_if bus ();

    mio_bus_ctrl dut (
        .clk(clk), .reset(reset), .bus(bus),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .sw(sw), .led(led), .cnt_irq(cnt_irq)
    );

    // external synchronous RAM
    logic [31:0] ram_mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    longint edges;
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // model: timer reloads from its last load value V at edge L, so it is V - (n mod (V+1))
    logic [31:0] m_mem [0:1023];
    logic [31:0] m_din;
    logic [15:0] m_led;
    longint      m_L, m_V, m_C;
    bit          m_sticky;

    function automatic logic [31:0] m_timer(input longint k);
        return 32'(m_V - ((k - m_L) % (m_V + 1)));
    endfunction

    // is there a wrap edge (timer 0 -> reload) of the current load in [a, b]
    function automatic bit m_wrap(input longint a, input longint b);
        longint p, j;
        p = m_V + 1;
        j = (a <= m_L) ? 1 : (a - m_L + p - 1) / p;
        if (j < 1) j = 1;
        return (m_L + j * p) <= b;
    endfunction

    function automatic bit m_irq(input longint k);
        return m_sticky || m_wrap(m_C, k);
    endfunction

    task automatic model_reset();
        m_L = 0; m_V = 64'hFFFF_FFFF; m_C = 0; m_sticky = 0;
        m_din = 0; m_led = 0;
    endtask

    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [15:0] swv, input bit toggle);
        longint e0, k;
        int     we_cnt, lat_exp;
        bit     seen, is_ram;
        @(negedge clk);
        bus.CPU_MIO = 1'b1; bus.mem_w = we; bus.Addr_out = addr; bus.Data_out = data; sw = swv;
        e0 = edges; we_cnt = 0; seen = 0;
        is_ram  = (addr[31:12] == 20'h0);
        lat_exp = is_ram ? 3 : 2;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (toggle) begin
                bus.CPU_MIO = 1'($urandom); bus.mem_w = 1'($urandom);
                bus.Addr_out = $urandom; bus.Data_out = $urandom;
            end
            if (ram_we) begin
                we_cnt++;
                check("ram_addr", 32'(ram_addr), 32'(addr[11:2]));
                check("ram_wdata", ram_wdata, data);
            end
            if (bus.MIO_ready) begin
                seen = 1;
                check("latency", 32'(edges - e0), 32'(lat_exp));
            end
        end
        bus.CPU_MIO = 1'b0;
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
        k = edges;
        if (is_ram) begin
            if (we) m_mem[addr[11:2]] = data;
            else    m_din = m_mem[addr[11:2]];
        end else begin
            case (addr)
                32'hF000_0000: if (we) m_led = data[15:0]; else m_din = {16'h0, swv};
                32'hF000_0004:
                    if (we) begin
                        m_sticky = m_sticky || m_wrap(m_C, k - 1);
                        m_L = k; m_V = 64'(data);
                    end else m_din = m_timer(k - 1);
                32'hF000_0008:
                    if (!we) begin
                        m_din = {31'h0, m_irq(k - 1)};
                        m_sticky = 0; m_C = k;
                    end
                default: if (!we) m_din = 32'h0;
            endcase
        end
        check("ram_we_pulses", 32'(we_cnt), (is_ram && we) ? 32'd1 : 32'd0);
        check("Data_in", bus.Data_in, m_din);
        check("led", 32'(led), 32'(m_led));
        check("cnt_irq", 32'(cnt_irq), 32'(m_irq(k)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(bus.MIO_ready), 32'd0);
            check("idle_irq", 32'(cnt_irq), 32'(m_irq(edges)));
        end
    endtask

    function automatic logic [31:0] rand_unmapped();
        logic [31:0] a;
        a = $urandom;
        for (int i = 0; i < 8; i++)
            if (a[31:12] == 20'h0 || a == 32'hF000_0000 || a == 32'hF000_0004 || a == 32'hF000_0008)
                a = $urandom;
        if (a[31:12] == 20'h0) a = 32'h1234_5678;
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint e0;
        int     pulses;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) begin ram_mem[i] = 32'h0; m_mem[i] = 32'h0; end
        bus.CPU_MIO = 0; bus.mem_w = 0; bus.Addr_out = 0; bus.Data_out = 0; sw = 0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_Data_in", bus.Data_in, 32'h0);
        check("rst_ready", 32'(bus.MIO_ready), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_irq", 32'(cnt_irq), 32'd0);
        reset = 1'b0;

        do_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0, 0);
        do_txn(0, 32'h0000_0010, 32'h0, 16'h0, 0);
        check("ram_readback", bus.Data_in, 32'hDEAD_BEEF);
        do_txn(1, 32'hF000_0000, 32'h0000_A5A5, 16'h0, 0);
        do_txn(0, 32'hF000_0000, 32'h0, 16'h1234, 0);
        check("sw_read", bus.Data_in, 32'h0000_1234);
        do_txn(0, 32'hF000_0004, 32'h0, 16'h0, 0);

        // timer reload 5: wrap every 6 edges, then clear coinciding with a wrap
        do_txn(1, 32'hF000_0004, 32'd5, 16'h0, 0);
        idle(14);
        do_txn(0, 32'hF000_0004, 32'h0, 16'h0, 0);
        do_txn(0, 32'hF000_0008, 32'h0, 16'h0, 0);
        check("irq_status", bus.Data_in, 32'h1);
        for (int i = 0; i < 12; i++)
            if ((edges + 3 - m_L) % (m_V + 1) != 0) @(negedge clk);
        do_txn(0, 32'hF000_0008, 32'h0, 16'h0, 0);
        check("irq_set_wins", 32'(cnt_irq), 32'd1);
        idle(4);

        do_txn(0, 32'h1234_5678, 32'h0, 16'h0, 0);
        check("unmapped_read", bus.Data_in, 32'h0);
        do_txn(1, 32'h1234_5678, 32'hFFFF_FFFF, 16'h0, 0);
        do_txn(1, 32'hF000_0008, 32'h1, 16'h0, 1);

        // back-to-back RAM reads with the request held high
        @(negedge clk);
        bus.CPU_MIO = 1; bus.mem_w = 0; bus.Addr_out = 32'h0000_0010;
        e0 = edges; pulses = 0;
        for (int i = 0; i < 24 && pulses < 4; i++) begin
            @(negedge clk);
            if (bus.MIO_ready) begin
                check("b2b_spacing", 32'(edges - e0), 32'(3 + 4 * pulses));
                check("b2b_data", bus.Data_in, m_mem[4]);
                pulses++;
                if (pulses == 4) bus.CPU_MIO = 0;
            end
        end
        check("b2b_count", 32'(pulses), 32'd4);
        idle(2);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0, 1: a = {20'h0, 12'($urandom)};
                2:    a = 32'hF000_0000;
                3:    a = 32'hF000_0004;
                4:    a = 32'hF000_0008;
                default: a = rand_unmapped();
            endcase
            if (a == 32'hF000_0004)
                do_txn(1'($urandom), a, $urandom_range(3, 40), 16'($urandom), 1'($urandom));
            else
                do_txn(1'($urandom), a, $urandom, 16'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 8));
        end

        // reset during the WAIT cycle of a RAM read
        do_txn(1, 32'h0000_0020, 32'h5555_AAAA, 16'h0, 0);
        do_txn(1, 32'hF000_0000, 32'h0000_00FF, 16'h0, 0);
        @(negedge clk);
        bus.CPU_MIO = 1; bus.mem_w = 0; bus.Addr_out = 32'h0000_0020;
        @(negedge clk);
        bus.CPU_MIO = 0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_ready", 32'(bus.MIO_ready), 32'd0);
        check("midrst_ram_we", 32'(ram_we), 32'd0);
        check("midrst_Data_in", bus.Data_in, 32'h0);
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_ram_addr", 32'(ram_addr), 32'd0);
        check("midrst_irq", 32'(cnt_irq), 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_ready", 32'(bus.MIO_ready), 32'd0);
        end
        reset = 1'b0;
        idle(2);
        do_txn(0, 32'hF000_0004, 32'h0, 16'h0, 0);
        do_txn(0, 32'h0000_0020, 32'h0, 16'h0, 0);
        check("post_rst_ram", bus.Data_in, 32'h5555_AAAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
